// File: rtl/ulx3s_pkg.sv
// Shared ULX3S board constants and helpers.
// Converts millisecond timing parameters into clock-cycle counts.
package ulx3s_pkg;

    localparam int CLK_HZ_DEFAULT = 25_000_000;

    function automatic int ms_to_cycles(input int clk_hz, input int ms);
        return (clk_hz / 1000) * ms;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button front end: 2-flop synchroniser, stable-time filter,
// rising-edge step pulse and optional hold auto-repeat.
module btn_debounce #(
    parameter int DB_CYCLES  = 250_000,
    parameter int RPT_CYCLES = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic pulse
);

    localparam int DB_W  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int RPT_W = (RPT_CYCLES > 1) ? $clog2(RPT_CYCLES) : 1;
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'((RPT_CYCLES > 0) ? RPT_CYCLES - 1 : 0);

    logic             sync1;
    logic             sync2;
    logic [DB_W-1:0]  db_cnt;
    logic [RPT_W-1:0] rpt_cnt;
    logic             db_flip;
    logic             level_next;
    logic             rpt_fire;

    always_comb begin
        db_flip    = (sync2 != level) && (db_cnt == DB_LAST);
        level_next = level ^ db_flip;
        rpt_fire   = 1'b0;
        // Repeat only while the level was already high and stays high this edge.
        if (RPT_CYCLES > 0) begin
            rpt_fire = level && level_next && (rpt_cnt == RPT_LAST);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            db_cnt  <= '0;
            level   <= 1'b0;
            rpt_cnt <= '0;
            pulse   <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            level <= level_next;
            pulse <= (db_flip && !level) || rpt_fire;

            if ((sync2 == level) || db_flip) begin
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end

            if ((RPT_CYCLES == 0) || !level_next || rpt_fire) begin
                rpt_cnt <= '0;
            end else if (level) begin
                rpt_cnt <= rpt_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/btn_counter_leds.sv
// Debounced up/down/clear button counter for the ULX3S LED bar, with
// wrap or saturate arithmetic and a sticky overflow flag.
module btn_counter_leds
    import ulx3s_pkg::*;
#(
    parameter int CLK_HZ      = CLK_HZ_DEFAULT,
    parameter int DEBOUNCE_MS = 10,
    parameter int REPEAT_MS   = 250,
    parameter int CNT_WIDTH   = 6,
    parameter int LED_WIDTH   = 8
) (
    input  logic                 clk_25mhz,
    input  logic                 rst,
    input  logic                 btn_inc,
    input  logic                 btn_dec,
    input  logic                 btn_clr,
    input  logic                 mode_sat,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 overflow,
    output logic [LED_WIDTH-1:0] led
);

    localparam int DB_RAW     = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
    localparam int DB_CYCLES  = (DB_RAW < 1) ? 1 : DB_RAW;
    localparam int RPT_CYCLES = ms_to_cycles(CLK_HZ, REPEAT_MS);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic inc_level, dec_level, clr_level;
    logic inc_pulse, dec_pulse, clr_pulse;
    logic [CNT_WIDTH-1:0] count_next;
    logic overflow_next;
    logic unused_levels;

    assign unused_levels = dec_level ^ clr_level;

    btn_debounce #(.DB_CYCLES(DB_CYCLES), .RPT_CYCLES(RPT_CYCLES)) u_inc (
        .clk(clk_25mhz), .rst(rst), .btn(btn_inc), .level(inc_level), .pulse(inc_pulse)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES), .RPT_CYCLES(RPT_CYCLES)) u_dec (
        .clk(clk_25mhz), .rst(rst), .btn(btn_dec), .level(dec_level), .pulse(dec_pulse)
    );

    // Clear is strictly edge-triggered: no repeat while held.
    btn_debounce #(.DB_CYCLES(DB_CYCLES), .RPT_CYCLES(0)) u_clr (
        .clk(clk_25mhz), .rst(rst), .btn(btn_clr), .level(clr_level), .pulse(clr_pulse)
    );

    always_comb begin
        count_next    = count;
        overflow_next = overflow;
        if (clr_pulse) begin
            count_next    = '0;
            overflow_next = 1'b0;
        end else if (inc_pulse ^ dec_pulse) begin
            // A blocked or wrapping step always raises the sticky flag.
            if (inc_pulse) begin
                if (count == CNT_MAX) begin
                    overflow_next = 1'b1;
                    if (!mode_sat) count_next = '0;
                end else begin
                    count_next = count + 1'b1;
                end
            end else begin
                if (count == '0) begin
                    overflow_next = 1'b1;
                    if (!mode_sat) count_next = CNT_MAX;
                end else begin
                    count_next = count - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_25mhz or posedge rst) begin
        if (rst) begin
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            count    <= count_next;
            overflow <= overflow_next;
        end
    end

    always_comb begin
        led                = '0;
        led[CNT_WIDTH-1:0] = count;
        led[CNT_WIDTH]     = overflow;
        led[CNT_WIDTH+1]   = inc_level;
    end

endmodule
